// File: rtl/display_timing_gen_if.sv
// Configuration and raster-output bundle between the register bank (master) and the timing generator (slave).
interface display_timing_gen_if #(
    parameter int CW  = 12,
    parameter int FCW = 16
);
    logic           cfg_enable;
    logic           cfg_hs_pol;
    logic           cfg_vs_pol;
    logic [CW-1:0]  cfg_h_active;
    logic [CW-1:0]  cfg_h_total;
    logic [CW-1:0]  cfg_hs_start;
    logic [CW-1:0]  cfg_hs_end;
    logic [CW-1:0]  cfg_v_active;
    logic [CW-1:0]  cfg_v_total;
    logic [CW-1:0]  cfg_vs_start;
    logic [CW-1:0]  cfg_vs_end;

    logic           hsync;
    logic           vsync;
    logic           de;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           line_start;
    logic           frame_start;
    logic           cfg_err;
    logic [FCW-1:0] frame_count;

    modport master (
        output cfg_enable, cfg_hs_pol, cfg_vs_pol,
               cfg_h_active, cfg_h_total, cfg_hs_start, cfg_hs_end,
               cfg_v_active, cfg_v_total, cfg_vs_start, cfg_vs_end,
        input  hsync, vsync, de, x, y, line_start, frame_start, cfg_err, frame_count
    );

    modport slave (
        input  cfg_enable, cfg_hs_pol, cfg_vs_pol,
               cfg_h_active, cfg_h_total, cfg_hs_start, cfg_hs_end,
               cfg_v_active, cfg_v_total, cfg_vs_start, cfg_vs_end,
        output hsync, vsync, de, x, y, line_start, frame_start, cfg_err, frame_count
    );
endinterface

// File: rtl/display_timing_gen.sv
// Raster timing generator: h/v counters with frame-boundary config shadowing and registered sync/de/markers.
// Outputs lag the counters by one pixel clock; free-running, no backpressure.
module display_timing_gen #(
    parameter int CW  = 12,
    parameter int FCW = 16
) (
    input  logic ACLK,
    input  logic ARESET,
    display_timing_gen_if.slave tif
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic          hs_pol;
        logic          vs_pol;
        logic [CW-1:0] h_active;
        logic [CW-1:0] h_total;
        logic [CW-1:0] hs_start;
        logic [CW-1:0] hs_end;
        logic [CW-1:0] v_active;
        logic [CW-1:0] v_total;
        logic [CW-1:0] vs_start;
        logic [CW-1:0] vs_end;
    } cfg_t;

    localparam logic [CW-1:0]  ZERO  = '0;
    localparam logic [CW-1:0]  ONE   = CW'(1);
    localparam logic [CW-1:0]  TWO   = CW'(2);
    localparam logic [FCW-1:0] FONE  = FCW'(1);

    state_t         state_q;
    cfg_t           shadow_q;
    logic [CW-1:0]  h_q, v_q;
    logic [FCW-1:0] fcnt_q;

    logic           hsync_q, vsync_q, de_q, ls_q, fs_q, err_q;
    logic [CW-1:0]  x_q, y_q;
    logic [FCW-1:0] fc_out_q;

    cfg_t live_cfg;
    logic live_ok, shadow_ok, h_last, v_last, hs_win, vs_win;

    function automatic logic cfg_valid(input cfg_t c);
        return (c.h_total >= TWO) && (c.h_active >= ONE) && (c.h_active <= c.h_total) &&
               (c.v_active >= ONE) && (c.v_active <= c.v_total);
    endfunction

    assign live_cfg = '{hs_pol:   tif.cfg_hs_pol,   vs_pol:   tif.cfg_vs_pol,
                        h_active: tif.cfg_h_active, h_total:  tif.cfg_h_total,
                        hs_start: tif.cfg_hs_start, hs_end:   tif.cfg_hs_end,
                        v_active: tif.cfg_v_active, v_total:  tif.cfg_v_total,
                        vs_start: tif.cfg_vs_start, vs_end:   tif.cfg_vs_end};

    assign live_ok   = cfg_valid(live_cfg);
    assign shadow_ok = cfg_valid(shadow_q);
    assign h_last    = (h_q == shadow_q.h_total - ONE);
    assign v_last    = (v_q == shadow_q.v_total - ONE);
    // An empty or inverted window never matches, which disables the sync without flagging an error.
    assign hs_win    = (h_q >= shadow_q.hs_start) && (h_q < shadow_q.hs_end);
    assign vs_win    = (v_q >= shadow_q.vs_start) && (v_q < shadow_q.vs_end);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            h_q      <= ZERO;
            v_q      <= ZERO;
            fcnt_q   <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            de_q     <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            err_q    <= 1'b0;
            x_q      <= ZERO;
            y_q      <= ZERO;
            fc_out_q <= '0;
        end else begin
            err_q    <= (state_q == IDLE) ? !live_ok : !shadow_ok;
            fc_out_q <= fcnt_q;
            if (state_q == RUN) begin
                de_q    <= (h_q < shadow_q.h_active) && (v_q < shadow_q.v_active);
                x_q     <= h_q;
                y_q     <= v_q;
                ls_q    <= (h_q == ZERO);
                fs_q    <= (h_q == ZERO) && (v_q == ZERO);
                hsync_q <= shadow_q.hs_pol ? hs_win : !hs_win;
                vsync_q <= shadow_q.vs_pol ? vs_win : !vs_win;
            end else begin
                de_q    <= 1'b0;
                x_q     <= ZERO;
                y_q     <= ZERO;
                ls_q    <= 1'b0;
                fs_q    <= 1'b0;
                hsync_q <= !shadow_q.hs_pol;
                vsync_q <= !shadow_q.vs_pol;
            end

            case (state_q)
                IDLE: begin
                    shadow_q <= live_cfg;
                    h_q      <= ZERO;
                    v_q      <= ZERO;
                    if (tif.cfg_enable && live_ok)
                        state_q <= RUN;
                end
                RUN: begin
                    if (!tif.cfg_enable) begin
                        state_q <= IDLE;
                        h_q     <= ZERO;
                        v_q     <= ZERO;
                    end else if (h_last) begin
                        h_q <= ZERO;
                        if (v_last) begin
                            // Frame boundary: the only point where software writes reach the raster.
                            v_q      <= ZERO;
                            fcnt_q   <= fcnt_q + FONE;
                            shadow_q <= live_cfg;
                            if (!live_ok)
                                state_q <= IDLE;
                        end else begin
                            v_q <= v_q + ONE;
                        end
                    end else begin
                        h_q <= h_q + ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tif.hsync       = hsync_q;
    assign tif.vsync       = vsync_q;
    assign tif.de          = de_q;
    assign tif.x           = x_q;
    assign tif.y           = y_q;
    assign tif.line_start  = ls_q;
    assign tif.frame_start = fs_q;
    assign tif.cfg_err     = err_q;
    assign tif.frame_count = fc_out_q;
endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench for display_timing_gen: 8x3 raster (4x2 active), hsync [5,6), vsync [2,3), FCW = 2.
module tb_display_timing_gen;
    localparam int CW  = 12;
    localparam int FCW = 2;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   fc_base = 0;

    always #5 ACLK = ~ACLK;

    display_timing_gen_if #(.CW(CW), .FCW(FCW)) tif();

    display_timing_gen #(.CW(CW), .FCW(FCW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .tif    (tif)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic load_cfg(input logic pol, input int ha);
        tif.cfg_hs_pol   = pol;
        tif.cfg_vs_pol   = pol;
        tif.cfg_h_active = CW'(ha);
        tif.cfg_h_total  = CW'(8);
        tif.cfg_hs_start = CW'(5);
        tif.cfg_hs_end   = CW'(6);
        tif.cfg_v_active = CW'(2);
        tif.cfg_v_total  = CW'(3);
        tif.cfg_vs_start = CW'(2);
        tif.cfg_vs_end   = CW'(3);
    endtask

    // Leaves the DUT one edge after IDLE->RUN, so the next tick shows frame_start.
    task automatic restart(input logic pol, input int ha);
        tif.cfg_enable = 1'b0;
        repeat (3) tick();
        load_cfg(pol, ha);
        tif.cfg_enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tif.cfg_enable = 1'b0;
        load_cfg(1'b0, 4);
        #2 ARESET = 1'b1;
        repeat (2) tick();
        checks++; if (tif.hsync !== 1'b1) begin errors++; $display("FAIL reset hsync got %b exp 1", tif.hsync); end
        checks++; if (tif.vsync !== 1'b1) begin errors++; $display("FAIL reset vsync got %b exp 1", tif.vsync); end
        checks++; if (tif.de !== 1'b0) begin errors++; $display("FAIL reset de got %b exp 0", tif.de); end
        checks++; if (tif.x !== CW'(0) || tif.y !== CW'(0)) begin errors++; $display("FAIL reset xy got %0d,%0d exp 0,0", tif.x, tif.y); end
        checks++; if (tif.line_start !== 1'b0 || tif.frame_start !== 1'b0) begin errors++; $display("FAIL reset pulses got %b%b exp 00", tif.line_start, tif.frame_start); end
        checks++; if (tif.cfg_err !== 1'b0) begin errors++; $display("FAIL reset cfg_err got %b exp 0", tif.cfg_err); end
        checks++; if (tif.frame_count !== FCW'(0)) begin errors++; $display("FAIL reset frame_count got %0d exp 0", tif.frame_count); end
        ARESET = 1'b0;
        fc_base = 0;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        load_cfg(1'b1, 4);
        tif.cfg_enable = 1'b1;
        tick();
        checks++; if (tif.frame_start !== 1'b0 || tif.de !== 1'b0) begin errors++; $display("FAIL basic first_edge fs/de got %b/%b exp 0/0", tif.frame_start, tif.de); end
        checks++; if (tif.hsync !== 1'b1) begin errors++; $display("FAIL basic idle_hsync got %b exp 1", tif.hsync); end
        for (int k = 0; k < 48; k++) begin
            int ex, ey;
            tick();
            ex = k % 8;
            ey = (k / 8) % 3;
            checks++; if (tif.x !== CW'(ex)) begin errors++; $display("FAIL basic x k=%0d got %0d exp %0d", k, tif.x, ex); end
            checks++; if (tif.y !== CW'(ey)) begin errors++; $display("FAIL basic y k=%0d got %0d exp %0d", k, tif.y, ey); end
            checks++; if (tif.de !== ((ex < 4) && (ey < 2))) begin errors++; $display("FAIL basic de k=%0d got %b", k, tif.de); end
            checks++; if (tif.hsync !== (ex == 5)) begin errors++; $display("FAIL basic hsync k=%0d got %b", k, tif.hsync); end
            checks++; if (tif.vsync !== (ey == 2)) begin errors++; $display("FAIL basic vsync k=%0d got %b", k, tif.vsync); end
            checks++; if (tif.line_start !== (ex == 0)) begin errors++; $display("FAIL basic line_start k=%0d got %b", k, tif.line_start); end
            checks++; if (tif.frame_start !== (k % 24 == 0)) begin errors++; $display("FAIL basic frame_start k=%0d got %b", k, tif.frame_start); end
            checks++; if (tif.frame_count !== FCW'((fc_base + k / 24) % 4)) begin errors++; $display("FAIL basic frame_count k=%0d got %0d exp %0d", k, tif.frame_count, (fc_base + k / 24) % 4); end
        end
        fc_base += 2;
    endtask

    task automatic test_pol_neg();
        restart(1'b0, 4);
        for (int k = 0; k < 48; k++) begin
            int ex, ey;
            tick();
            ex = k % 8;
            ey = (k / 8) % 3;
            checks++; if (tif.x !== CW'(ex) || tif.y !== CW'(ey)) begin errors++; $display("FAIL neg xy k=%0d got %0d,%0d exp %0d,%0d", k, tif.x, tif.y, ex, ey); end
            checks++; if (tif.hsync !== (ex != 5)) begin errors++; $display("FAIL neg hsync k=%0d got %b", k, tif.hsync); end
            checks++; if (tif.vsync !== (ey != 2)) begin errors++; $display("FAIL neg vsync k=%0d got %b", k, tif.vsync); end
            checks++; if (tif.de !== ((ex < 4) && (ey < 2))) begin errors++; $display("FAIL neg de k=%0d got %b", k, tif.de); end
            checks++; if (tif.frame_count !== FCW'((fc_base + k / 24) % 4)) begin errors++; $display("FAIL neg frame_count k=%0d got %0d exp %0d", k, tif.frame_count, (fc_base + k / 24) % 4); end
        end
        fc_base += 2;
    endtask

    task automatic test_shadow();
        restart(1'b1, 4);
        for (int k = 0; k < 48; k++) begin
            int ex, ey, ha;
            tick();
            ex = k % 8;
            ey = (k / 8) % 3;
            ha = (k < 24) ? 4 : 6;
            checks++; if (tif.de !== ((ex < ha) && (ey < 2))) begin errors++; $display("FAIL shadow de k=%0d got %b exp width %0d", k, tif.de, ha); end
            checks++; if (tif.frame_start !== (k % 24 == 0)) begin errors++; $display("FAIL shadow frame_start k=%0d got %b", k, tif.frame_start); end
            if (k == 5) tif.cfg_h_active = CW'(6);
        end
        fc_base += 2;
    endtask

    task automatic test_cfg_err();
        tif.cfg_enable = 1'b0;
        repeat (3) tick();
        load_cfg(1'b1, 4);
        tif.cfg_h_total = CW'(1);
        tif.cfg_enable  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (tif.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err high i=%0d got %b exp 1", i, tif.cfg_err); end
            checks++; if (tif.de !== 1'b0 || tif.frame_start !== 1'b0 || tif.x !== CW'(0)) begin errors++; $display("FAIL cfg_err idle i=%0d de=%b fs=%b x=%0d exp 0,0,0", i, tif.de, tif.frame_start, tif.x); end
        end
        tif.cfg_h_total = CW'(8);
        tick();
        checks++; if (tif.cfg_err !== 1'b0 || tif.frame_start !== 1'b0) begin errors++; $display("FAIL cfg_err clear err=%b fs=%b exp 0,0", tif.cfg_err, tif.frame_start); end
        tick();
        checks++; if (tif.frame_start !== 1'b1 || tif.line_start !== 1'b1) begin errors++; $display("FAIL cfg_err start fs=%b ls=%b exp 1,1", tif.frame_start, tif.line_start); end
        checks++; if (tif.x !== CW'(0) || tif.y !== CW'(0) || tif.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err run x=%0d y=%0d err=%b exp 0,0,0", tif.x, tif.y, tif.cfg_err); end
    endtask

    task automatic test_disable();
        restart(1'b1, 4);
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++; if (tif.x !== CW'(k % 8) || tif.y !== CW'(k / 8)) begin errors++; $display("FAIL disable pre k=%0d got %0d,%0d exp %0d,%0d", k, tif.x, tif.y, k % 8, k / 8); end
        end
        tif.cfg_enable = 1'b0;
        repeat (2) tick();
        checks++; if (tif.de !== 1'b0 || tif.x !== CW'(0) || tif.y !== CW'(0)) begin errors++; $display("FAIL disable stop de=%b x=%0d y=%0d exp 0,0,0", tif.de, tif.x, tif.y); end
        checks++; if (tif.frame_count !== FCW'(fc_base % 4)) begin errors++; $display("FAIL disable frame_count got %0d exp %0d", tif.frame_count, fc_base % 4); end
        repeat (3) tick();
        checks++; if (tif.frame_start !== 1'b0 || tif.line_start !== 1'b0) begin errors++; $display("FAIL disable idle pulses fs=%b ls=%b exp 0,0", tif.frame_start, tif.line_start); end
        tif.cfg_enable = 1'b1;
        tick();
        checks++; if (tif.frame_start !== 1'b0) begin errors++; $display("FAIL reenable early fs got %b exp 0", tif.frame_start); end
        tick();
        checks++; if (tif.frame_start !== 1'b1 || tif.x !== CW'(0) || tif.y !== CW'(0)) begin errors++; $display("FAIL reenable start fs=%b x=%0d y=%0d exp 1,0,0", tif.frame_start, tif.x, tif.y); end
        checks++; if (tif.frame_count !== FCW'(fc_base % 4)) begin errors++; $display("FAIL reenable frame_count got %0d exp %0d", tif.frame_count, fc_base % 4); end
    endtask

    task automatic test_fcw_wrap();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        #2 ARESET = 1'b1;
        load_cfg(1'b1, 4);
        tif.cfg_enable = 1'b1;
        tick();
        checks++; if (tif.frame_count !== FCW'(0)) begin errors++; $display("FAIL wrap reset frame_count got %0d exp 0", tif.frame_count); end
        ARESET  = 1'b0;
        fc_base = 0;
        tick();
        for (int k = 0; k < 122; k++) begin
            tick();
            checks++; if (tif.frame_start !== (k % 24 == 0)) begin errors++; $display("FAIL wrap frame_start k=%0d got %b", k, tif.frame_start); end
            if (k % 24 == 0) begin
                checks++; if (tif.frame_count !== FCW'(seq[k / 24])) begin errors++; $display("FAIL wrap frame_count k=%0d got %0d exp %0d", k, tif.frame_count, seq[k / 24]); end
            end
        end
        #3 ARESET = 1'b1;
        #1;
        checks++; if (tif.hsync !== 1'b1 || tif.vsync !== 1'b1) begin errors++; $display("FAIL async_reset syncs got %b%b exp 11", tif.hsync, tif.vsync); end
        checks++; if (tif.de !== 1'b0 || tif.x !== CW'(0) || tif.y !== CW'(0)) begin errors++; $display("FAIL async_reset de=%b x=%0d y=%0d exp 0,0,0", tif.de, tif.x, tif.y); end
        checks++; if (tif.line_start !== 1'b0 || tif.frame_start !== 1'b0 || tif.cfg_err !== 1'b0) begin errors++; $display("FAIL async_reset ls=%b fs=%b err=%b exp 0,0,0", tif.line_start, tif.frame_start, tif.cfg_err); end
        checks++; if (tif.frame_count !== FCW'(0)) begin errors++; $display("FAIL async_reset frame_count got %0d exp 0", tif.frame_count); end
        tick();
        ARESET = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pol_neg();
        test_shadow();
        test_cfg_err();
        test_disable();
        test_fcw_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
